// File: rtl/branch_predictor_if.sv
// Fetch/resolve signal bundle for the 2-bit branch predictor.
// Statistics signals exist only when BP_STATS_EN is defined.
interface branch_predictor_if;
    logic [31:0] pc_if;
    logic        predict_taken;
    logic        update;
    logic [31:0] update_pc;
    logic        actual_taken;
    logic        predicted_taken_ex;
    logic        mispredict;
`ifdef BP_STATS_EN
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;
`endif

    modport master (
        output pc_if, update, update_pc, actual_taken, predicted_taken_ex,
        input  predict_taken, mispredict
`ifdef BP_STATS_EN
        , input branch_count, mispredict_count
`endif
    );

    modport slave (
        input  pc_if, update, update_pc, actual_taken, predicted_taken_ex,
        output predict_taken, mispredict
`ifdef BP_STATS_EN
        , output branch_count, mispredict_count
`endif
    );
endinterface

// File: rtl/branch_predictor.sv
// Untagged table of 2-bit saturating counters indexed by PC[INDEX_BITS+1:2].
// Optional statistics counters are enabled with macro BP_STATS_EN.
module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);
    localparam int NUM_ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            r_table [NUM_ENTRIES];
    logic                  r_mispredict;
    logic [INDEX_BITS-1:0] w_lookup_idx;
    logic [INDEX_BITS-1:0] w_update_idx;
    logic                  w_mispredict_next;
    logic                  w_unused;

    assign w_lookup_idx      = bp.pc_if[INDEX_BITS+1:2];
    assign w_update_idx      = bp.update_pc[INDEX_BITS+1:2];
    assign w_mispredict_next = bp.update && (bp.predicted_taken_ex != bp.actual_taken);
    assign w_unused          = ^{bp.pc_if[31:INDEX_BITS+2], bp.pc_if[1:0],
                                 bp.update_pc[31:INDEX_BITS+2], bp.update_pc[1:0]};

    // Reads the pre-edge table value; a same-cycle update is not bypassed.
    assign bp.predict_taken = r_table[w_lookup_idx][1];
    assign bp.mispredict    = r_mispredict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_table[i] <= 2'b01;
            end
            r_mispredict <= 1'b0;
        end else begin
            r_mispredict <= w_mispredict_next;
            if (bp.update) begin
                if (bp.actual_taken && (r_table[w_update_idx] != 2'b11)) begin
                    r_table[w_update_idx] <= r_table[w_update_idx] + 2'b01;
                end else if (!bp.actual_taken && (r_table[w_update_idx] != 2'b00)) begin
                    r_table[w_update_idx] <= r_table[w_update_idx] - 2'b01;
                end
            end
        end
    end

`ifdef BP_STATS_EN
    logic [15:0] r_branch_count;
    logic [15:0] r_mispredict_count;

    // Both counters wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_count     <= 16'h0000;
            r_mispredict_count <= 16'h0000;
        end else begin
            if (bp.update) begin
                r_branch_count <= r_branch_count + 16'h0001;
            end
            if (w_mispredict_next) begin
                r_mispredict_count <= r_mispredict_count + 16'h0001;
            end
        end
    end

    assign bp.branch_count     = r_branch_count;
    assign bp.mispredict_count = r_mispredict_count;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus random traffic
// against an arithmetic model of the counter table.
module tb_branch_predictor;
    logic clk;
    logic rst_n;

    branch_predictor_if bus ();

    branch_predictor #(.INDEX_BITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        pred;
        logic        mis;
        logic [31:0] pc;
        int          bc;
        int          mc;
    } exp_t;

    exp_t q_exp[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: counter values 0..3, prediction is "value >= 2".
    int   m_tbl [16];
    logic m_mis;
    int   m_bc;
    int   m_mc;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tbl[i] = 1;
        m_mis = 1'b0;
        m_bc  = 0;
        m_mc  = 0;
    endtask

    // One clock cycle of stimulus, driven 1 time unit after the rising edge.
    task automatic cycle(input logic rst, input logic upd, input logic act,
                         input logic pex, input logic [31:0] pcif,
                         input logic [31:0] upc);
        exp_t e;
        int   li;
        int   ui;
        @(posedge clk);
        #1;
        rst_n                  = rst;
        bus.pc_if              = pcif;
        bus.update             = upd;
        bus.update_pc          = upc;
        bus.actual_taken       = act;
        bus.predicted_taken_ex = pex;
        li = int'((pcif >> 2) & 32'hF);
        ui = int'((upc >> 2) & 32'hF);
        e.pc = pcif;
        if (!rst) begin
            model_reset();
            e.pred = 1'b0;
            e.mis  = 1'b0;
            e.bc   = 0;
            e.mc   = 0;
        end else begin
            e.pred = (m_tbl[li] >= 2);
            e.mis  = m_mis;
            e.bc   = m_bc;
            e.mc   = m_mc;
            m_mis  = upd && (pex != act);
            if (upd) begin
                if (act) m_tbl[ui] = (m_tbl[ui] == 3) ? 3 : m_tbl[ui] + 1;
                else     m_tbl[ui] = (m_tbl[ui] == 0) ? 0 : m_tbl[ui] - 1;
                m_bc = (m_bc + 1) % 65536;
                if (m_mis) m_mc = (m_mc + 1) % 65536;
            end
        end
        q_exp.push_back(e);
    endtask

    task automatic idle(input logic [31:0] pcif);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, pcif, 32'h0);
    endtask

    // Monitor: every cycle the DUT presents a prediction and a flush flag.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                checks++;
                if (bus.predict_taken !== e.pred) begin
                    errors++;
                    $display("FAIL predict_taken pc=%h got=%b exp=%b t=%0t",
                             e.pc, bus.predict_taken, e.pred, $time);
                end
                checks++;
                if (bus.mispredict !== e.mis) begin
                    errors++;
                    $display("FAIL mispredict got=%b exp=%b t=%0t",
                             bus.mispredict, e.mis, $time);
                end
`ifdef BP_STATS_EN
                checks++;
                if (bus.branch_count !== 16'(e.bc)) begin
                    errors++;
                    $display("FAIL branch_count got=%0d exp=%0d t=%0t",
                             bus.branch_count, e.bc, $time);
                end
                checks++;
                if (bus.mispredict_count !== 16'(e.mc)) begin
                    errors++;
                    $display("FAIL mispredict_count got=%0d exp=%0d t=%0t",
                             bus.mispredict_count, e.mc, $time);
                end
`endif
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst_n                  = 1'b0;
        bus.pc_if              = 32'h0;
        bus.update             = 1'b0;
        bus.update_pc          = 32'h0;
        bus.actual_taken       = 1'b0;
        bus.predicted_taken_ex = 1'b0;
        model_reset();

        // Updates while in reset must be ignored.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) idle(32'(i * 4));

        // Taken update at 0x40 aliases to index 0.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h40);
        idle(32'h40);
        idle(32'h00);

        // Index 3: five taken, then two not-taken.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 32'h0C);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0C, 32'h0C);
        idle(32'h0C);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0C, 32'h0C);
        idle(32'h0C);

        // Mispredict pulse, then a correct prediction.
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h24);
        idle(32'h20);
        idle(32'h20);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h24);
        idle(32'h20);

        // Same-cycle lookup and update of a WN entry.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 32'h08);
        idle(32'h08);

        // Train a few entries to ST, then reset between edges.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h10);
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h14, 32'h14);
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h18, 32'h18);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h10);
        for (int i = 0; i < 16; i++) idle(32'(i * 4));

        // Random traffic biased onto few indices so counters saturate.
        for (int n = 0; n < 400; n++) begin
            a = $urandom();
            b = $urandom();
            if ($urandom_range(0, 3) != 0) b = (b & 32'hFFFF_FFC3) | 32'(($urandom_range(0, 3)) << 2);
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, b);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        repeat (4) @(negedge clk);
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", q_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
